// File: rtl/alu_arb_pkg.sv
// Shared types and default sizing for the ALU request arbiter.
// Holds the FSM state type, its encodings and the default parameter widths.
package alu_arb_pkg;

  localparam int FUN_WD_DEF      = 4;
  localparam int OUT_WD_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_GATE_ON = 3'd1;
  localparam state_t ST_ISSUE   = 3'd2;
  localparam state_t ST_WAIT    = 3'd3;
  localparam state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to
// the requester that was not granted last (last=1 means requester 1 had it).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] sel
);

  always_comb begin
    sel = 2'b00;
    case (req)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = last ? 2'b01 : 2'b10;
      default: sel = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two requesters onto one clock-gated ALU and routes the result back.
// Define ALU_ARB_TIMEOUT_EN to add a WAIT watchdog that returns an error response.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int FUN_WD      = FUN_WD_DEF,
  parameter int OUT_WD      = OUT_WD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        REQ,
  input  logic [FUN_WD-1:0] REQ_FUN0,
  input  logic [FUN_WD-1:0] REQ_FUN1,
  output logic [1:0]        GNT,
  output logic [1:0]        RSP_VALID,
  output logic [OUT_WD-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic              GATE_EN,
  output logic              ALU_EN,
  output logic [FUN_WD-1:0] ALU_FUN,
  input  logic [OUT_WD-1:0] ALU_OUT,
  input  logic              ALU_OUT_VALID,
  output logic              BUSY
);

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [OUT_WD-1:0] rsp_data_q, rsp_data_d;
  logic              gate_en_q, gate_en_d;
  logic              alu_en_q, alu_en_d;
  logic [FUN_WD-1:0] alu_fun_q, alu_fun_d;
  logic              busy_q, busy_d;
  logic [1:0]        rr_sel;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_WD = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TIMEOUT_CYC - 1);

  logic [CNT_WD-1:0] wait_cnt_q, wait_cnt_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  rr_arbiter2 u_rr (
    .req  (REQ),
    .last (last_q),
    .sel  (rr_sel)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rsp_data_d = rsp_data_q;
    alu_fun_d  = alu_fun_q;
`ifdef ALU_ARB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    rsp_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          owner_d   = rr_sel;
          alu_fun_d = rr_sel[1] ? REQ_FUN1 : REQ_FUN0;
          state_d   = ST_GATE_ON;
        end
      end
      ST_GATE_ON: state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (ALU_OUT_VALID) begin
          rsp_data_d = ALU_OUT;
          state_d    = ST_RESP;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        last_d  = owner_q[1];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    gnt_d       = (state_d == ST_GATE_ON) ? owner_d : 2'b00;
    rsp_valid_d = (state_d == ST_RESP) ? owner_q : 2'b00;
    gate_en_d   = (state_d == ST_GATE_ON) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    alu_en_d    = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'b00;
      last_q      <= 1'b1;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      gate_en_q   <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      gate_en_q   <= gate_en_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign RSP_ERR = rsp_err_q;
`else
  assign RSP_ERR = 1'b0;
`endif

  assign GNT       = gnt_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign GATE_EN   = gate_en_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: reset, single request, round-robin,
// ignored valids, watchdog (either build) and reset in the middle of WAIT.
module tb_alu_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  req_fun0, req_fun1;
  logic [1:0]  gnt, rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err, gate_en, alu_en, busy;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        alu_out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_req_arbiter dut (
    .CLK           (clk),
    .RST           (rst_n),
    .REQ           (req),
    .REQ_FUN0      (req_fun0),
    .REQ_FUN1      (req_fun1),
    .GNT           (gnt),
    .RSP_VALID     (rsp_valid),
    .RSP_DATA      (rsp_data),
    .RSP_ERR       (rsp_err),
    .GATE_EN       (gate_en),
    .ALU_EN        (alu_en),
    .ALU_FUN       (alu_fun),
    .ALU_OUT       (alu_out),
    .ALU_OUT_VALID (alu_out_valid),
    .BUSY          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; req_fun0 = '0; req_fun1 = '0;
    alu_out = '0; alu_out_valid = 1'b0;
    repeat (2) tick();
    n_cmp++; if ({gnt, rsp_valid, rsp_err, gate_en, alu_en, busy} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000000", {gnt, rsp_valid, rsp_err, gate_en, alu_en, busy}); end
    n_cmp++; if (alu_fun !== 4'h0) begin
      n_fail++; $display("FAIL reset_alu_fun: got %h want 0", alu_fun); end
    n_cmp++; if (rsp_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++; if ({busy, gnt} !== 3'b000) begin
      n_fail++; $display("FAIL idle_no_req: got %b want 000", {busy, gnt}); end
  endtask

  task automatic test_single_req();
    req = 2'b01; req_fun0 = 4'h2; req_fun1 = 4'hF;
    tick();
    n_cmp++; if ({gnt, gate_en, busy, alu_en} !== 5'b01110) begin
      n_fail++; $display("FAIL single_c1: got %b want 01110", {gnt, gate_en, busy, alu_en}); end
    req = 2'b00;
    tick();
    n_cmp++; if ({alu_en, alu_fun, gnt, gate_en} !== {1'b1, 4'h2, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL single_c2: got %b want %b", {alu_en, alu_fun, gnt, gate_en}, {1'b1, 4'h2, 2'b00, 1'b1}); end
    tick();
    n_cmp++; if ({alu_en, gate_en, rsp_valid} !== 4'b0100) begin
      n_fail++; $display("FAIL single_c3: got %b want 0100", {alu_en, gate_en, rsp_valid}); end
    alu_out = 16'h0030; alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0; alu_out = 16'hFFFF;
    n_cmp++; if ({rsp_valid, rsp_err, gate_en, busy} !== 5'b01001) begin
      n_fail++; $display("FAIL single_c4_ctrl: got %b want 01001", {rsp_valid, rsp_err, gate_en, busy}); end
    n_cmp++; if (rsp_data !== 16'h0030) begin
      n_fail++; $display("FAIL single_c4_data: got %h want 0030", rsp_data); end
    tick();
    n_cmp++; if ({rsp_valid, busy, rsp_data, alu_fun} !== {2'b00, 1'b0, 16'h0030, 4'h2}) begin
      n_fail++; $display("FAIL single_c5_idle: got %h want %h", {rsp_valid, busy, rsp_data, alu_fun}, {2'b00, 1'b0, 16'h0030, 4'h2}); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt;
    logic [3:0]  exp_fun;
    logic [15:0] exp_data;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11; req_fun0 = 4'h5; req_fun1 = 4'hA;
    for (int t = 0; t < 2; t++) begin
      exp_gnt  = (t == 0) ? 2'b01 : 2'b10;
      exp_fun  = (t == 0) ? 4'h5 : 4'hA;
      exp_data = (t == 0) ? 16'h1111 : 16'h2222;
      tick();
      n_cmp++; if (gnt !== exp_gnt) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", t, gnt, exp_gnt); end
      tick();
      n_cmp++; if ({alu_en, alu_fun} !== {1'b1, exp_fun}) begin
        n_fail++; $display("FAIL rr_issue[%0d]: got %b want %b", t, {alu_en, alu_fun}, {1'b1, exp_fun}); end
      tick();
      alu_out = exp_data; alu_out_valid = 1'b1;
      tick();
      alu_out_valid = 1'b0;
      n_cmp++; if ({rsp_valid, rsp_data} !== {exp_gnt, exp_data}) begin
        n_fail++; $display("FAIL rr_resp[%0d]: got %h want %h", t, {rsp_valid, rsp_data}, {exp_gnt, exp_data}); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin
        n_fail++; $display("FAIL rr_idle[%0d]: got %b want 0", t, busy); end
    end
    req = 2'b00;
  endtask

  task automatic test_ignored_valid();
    alu_out = 16'hDEAD; alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++; if ({rsp_valid, busy, rsp_data} !== {2'b00, 1'b0, 16'h2222}) begin
      n_fail++; $display("FAIL valid_in_idle: got %h want %h", {rsp_valid, busy, rsp_data}, {2'b00, 1'b0, 16'h2222}); end
    req = 2'b01; req_fun0 = 4'h3;
    tick();
    req = 2'b00;
    n_cmp++; if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL dropped_req_gnt: got %b want 01", gnt); end
    tick();
    alu_out = 16'hBEEF; alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++; if ({rsp_valid, busy, gate_en, rsp_data} !== {2'b00, 1'b1, 1'b1, 16'h2222}) begin
      n_fail++; $display("FAIL valid_in_issue: got %h want %h", {rsp_valid, busy, gate_en, rsp_data}, {2'b00, 1'b1, 1'b1, 16'h2222}); end
    tick();
    alu_out = 16'h0777; alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_data} !== {2'b01, 16'h0777}) begin
      n_fail++; $display("FAIL late_valid_resp: got %h want %h", {rsp_valid, rsp_data}, {2'b01, 16'h0777}); end
    tick();
  endtask

  task automatic test_timeout();
    req = 2'b10; req_fun1 = 4'h9;
    tick();
    req = 2'b00;
    n_cmp++; if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL to_gnt: got %b want 10", gnt); end
    tick();
    repeat (8) tick();
    n_cmp++; if ({rsp_valid, busy, gate_en} !== 4'b0011) begin
      n_fail++; $display("FAIL to_wait8: got %b want 0011", {rsp_valid, busy, gate_en}); end
    tick();
`ifdef ALU_ARB_TIMEOUT_EN
    n_cmp++; if ({rsp_valid, rsp_err, gate_en, rsp_data} !== {2'b10, 1'b1, 1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL to_resp: got %h want %h", {rsp_valid, rsp_err, gate_en, rsp_data}, {2'b10, 1'b1, 1'b0, 16'h0000}); end
    tick();
    n_cmp++; if ({rsp_valid, rsp_err, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL to_idle: got %b want 0000", {rsp_valid, rsp_err, busy}); end
`else
    repeat (10) tick();
    n_cmp++; if ({rsp_valid, rsp_err, busy, gate_en} !== 5'b00011) begin
      n_fail++; $display("FAIL no_to_still_wait: got %b want 00011", {rsp_valid, rsp_err, busy, gate_en}); end
    alu_out = 16'h5A5A; alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b0, 16'h5A5A}) begin
      n_fail++; $display("FAIL no_to_resp: got %h want %h", {rsp_valid, rsp_err, rsp_data}, {2'b10, 1'b0, 16'h5A5A}); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_wait();
    req = 2'b01; req_fun0 = 4'h6;
    tick();
    req = 2'b00;
    tick();
    tick();
    n_cmp++; if ({busy, gate_en} !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre_wait: got %b want 11", {busy, gate_en}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({gate_en, alu_en, busy, gnt, rsp_valid, rsp_err} !== 8'h00) begin
      n_fail++; $display("FAIL rst_async_ctrl: got %b want 00000000", {gate_en, alu_en, busy, gnt, rsp_valid, rsp_err}); end
    n_cmp++; if ({alu_fun, rsp_data} !== 20'h00000) begin
      n_fail++; $display("FAIL rst_async_data: got %h want 00000", {alu_fun, rsp_data}); end
    tick();
    rst_n = 1'b1;
    req = 2'b10; req_fun1 = 4'hC;
    tick();
    req = 2'b00;
    n_cmp++; if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL post_rst_gnt: got %b want 10", gnt); end
    tick();
    n_cmp++; if ({alu_en, alu_fun} !== {1'b1, 4'hC}) begin
      n_fail++; $display("FAIL post_rst_issue: got %b want %b", {alu_en, alu_fun}, {1'b1, 4'hC}); end
    tick();
    alu_out = 16'hABCD; alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b0, 16'hABCD}) begin
      n_fail++; $display("FAIL post_rst_resp: got %h want %h", {rsp_valid, rsp_err, rsp_data}, {2'b10, 1'b0, 16'hABCD}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_ignored_valid();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter FUN_WD, default 4, SHALL set the ALU function code width.
REQ-002 Parameter OUT_WD, default 16, SHALL set the ALU result width.
REQ-003 Parameter TIMEOUT_CYC, default 8, SHALL set the WAIT-state watchdog limit in cycles.
REQ-004 CLK  input  1  SHALL be the single clock; the ungated REF-domain clock, with all logic on the rising edge.
REQ-005 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 REQ  input  2  SHALL carry the per-requester level request, held until GNT.
REQ-007 REQ_FUN0, REQ_FUN1  input  FUN_WD  SHALL carry the function code of requester 0 and requester 1.
REQ-008 GNT  output  2  SHALL be a one-hot, one-cycle acceptance pulse.
REQ-009 RSP_VALID  output  2  SHALL be a one-hot, one-cycle response pulse to the owning requester.
REQ-010 RSP_DATA  output  OUT_WD  SHALL carry the captured result, held until the next response.
REQ-011 RSP_ERR  output  1  SHALL flag a timeout response, valid with RSP_VALID.
REQ-012 GATE_EN  output  1  SHALL drive the clock-gate enable of the ALU clock.
REQ-013 ALU_EN  output  1  SHALL drive the ALU operation strobe.
REQ-014 ALU_FUN  output  FUN_WD  SHALL carry the function code issued to the ALU.
REQ-015 ALU_OUT  input  OUT_WD  SHALL carry the ALU result.
REQ-016 ALU_OUT_VALID  input  1  SHALL carry the ALU result-valid pulse.
REQ-017 BUSY  output  1  SHALL be high in every state except IDLE.

Function
REQ-018 The FSM SHALL use the states IDLE, GATE_ON, ISSUE, WAIT and RESP, and all outputs SHALL be registered.
REQ-019 IDLE: when any REQ bit is high, the FSM SHALL select an owner round-robin, latch that owner's FUN, and move to GATE_ON; with no REQ bit high it SHALL stay in IDLE.
REQ-020 Round-robin: when both requests are high, the requester not granted last SHALL win; a single request SHALL always win.
REQ-021 GATE_ON (1 cycle): GNT[owner]=1 and GATE_EN=1, then the FSM SHALL move to ISSUE.
REQ-022 ISSUE (1 cycle): ALU_EN=1, ALU_FUN=latched FUN and GATE_EN=1, then the FSM SHALL move to WAIT.
REQ-023 WAIT: GATE_EN SHALL stay 1; on ALU_OUT_VALID=1 the FSM SHALL capture ALU_OUT and move to RESP.
REQ-024 RESP (1 cycle): RSP_VALID[owner]=1, GATE_EN=0, the last-granted pointer SHALL update to the owner, and the FSM SHALL return to IDLE.
REQ-025 Minimum latency SHALL be 4 cycles from REQ sampled in IDLE (cycle 0) to RSP_VALID (cycle 4), given ALU_OUT_VALID in cycle 3.
REQ-026 REQ changes outside IDLE SHALL be ignored; a request deasserted after sampling SHALL still complete, including GNT.
REQ-027 ALU_OUT_VALID outside WAIT SHALL be ignored.
REQ-028 ALU_FUN SHALL hold the last latched value while the FSM is in IDLE.

Reset
REQ-029 Reset assertion SHALL, asynchronously and at any state including mid-operation, force IDLE; clear GNT, RSP_VALID, RSP_ERR, GATE_EN, ALU_EN and BUSY to 0; clear ALU_FUN and RSP_DATA to 0; and set the pointer so requester 0 wins the first tie.
REQ-030 Following reset release, the first rising edge SHALL evaluate IDLE normally.

Configuration
REQ-031 With ALU_ARB_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; after TIMEOUT_CYC cycles without ALU_OUT_VALID the FSM SHALL enter RESP with RSP_ERR=1 and RSP_DATA=0.
REQ-032 With ALU_ARB_TIMEOUT_EN defined, the counter SHALL clear on WAIT entry.
REQ-033 Without ALU_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, RSP_ERR SHALL be tied to 0, and no counter logic SHALL be built.

Structure
REQ-034 Package alu_arb_pkg SHALL hold the FSM state typedef, the state encodings and the default width constants.
REQ-035 The two-way round-robin selection SHALL be a sub-module named rr_arbiter2, with inputs req[1:0] and last, and output one-hot sel.

Verification
REQ-036 Reset, REQ=01, FUN0=4'h2, ALU_OUT=16'h0030 with valid in cycle 3 -> GNT=01 in cycle 1, ALU_EN with ALU_FUN=2 in cycle 2, RSP_VALID=01 with RSP_DATA=0x0030 in cycle 4.
REQ-037 REQ=11 held across two transactions -> grants 01 then 10, with responses routed to the matching owners.
REQ-038 ALU_OUT_VALID pulsed in IDLE and in ISSUE -> no capture and no RSP_VALID.
REQ-039 With ALU_ARB_TIMEOUT_EN and no valid for 8 WAIT cycles -> RSP_VALID with RSP_ERR=1 and RSP_DATA=0, then return to IDLE; without the macro -> FSM remains in WAIT.
REQ-040 RST asserted in WAIT -> GATE_EN, ALU_EN and BUSY drop to 0 immediately, and the next REQ=10 is serviced normally.
